pipeline_sequencer: RTL

Central stall, flush and halt sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It consumes ID-stage decode fields, EX-stage hazard and redirect information, and the MEM-stage data-memory handshake. From these it drives the pipeline-register enables and flushes. It owns the halt-drain sequence and the data-memory wait timeout, and exposes a saturating stall counter for performance debug.

---
 rtl/pipeline_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt sequencer for a 5-stage RISC-V pipeline: Mealy control of the
// pipeline-register enables and flushes, halt drain, data-memory wait timeout and stall counter.
module pipeline_sequencer #(
    parameter int MAX_WAIT     = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0000001;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED,
        ST_ERROR
    } state_t;

    state_t              r_state;
    state_t              r_ret_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;

    state_t              w_eval_state;
    state_t              w_next_state;
    state_t              w_next_ret;
    logic [WAIT_W-1:0]   w_next_wait;
    logic [DRAIN_W-1:0]  w_next_drain;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_load_use;
    logic                w_is_halt;
    logic                w_mem_stall;
    logic                w_pc_en;
    logic                w_if_id_en;
    logic                w_id_ex_en;
    logic                w_ex_mem_en;
    logic                w_if_id_flush;
    logic                w_id_ex_flush;
    logic                w_bubble;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (id_opcode)
            OP_R, OP_BR, OP_ST: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_LD, OP_IMM, OP_JALR: w_use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign w_load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                         ((w_use_rs1 && (ex_rd == id_rs1)) || (w_use_rs2 && (ex_rd == id_rs2)));
    assign w_is_halt   = (id_opcode == OP_HALT);
    assign w_mem_stall = mem_req && !dmem_ready;

    // A completed wait is evaluated exactly as the state it interrupted.
    assign w_eval_state = ((r_state == ST_MEM_WAIT) && dmem_ready) ? r_ret_state : r_state;

    always_comb begin
        w_next_state  = r_state;
        w_next_ret    = r_ret_state;
        w_next_wait   = r_wait_cnt;
        w_next_drain  = r_drain_cnt;
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_id_ex_en    = 1'b0;
        w_ex_mem_en   = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_bubble      = 1'b0;
        case (w_eval_state)
            ST_RUN, ST_DRAIN: begin
                if (w_mem_stall) begin
                    w_bubble     = 1'b1;
                    w_next_wait  = WAIT_W'(1);
                    w_next_ret   = w_eval_state;
                    w_next_state = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b1111;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_next_state  = ST_RUN;
                end else if (w_eval_state == ST_DRAIN) begin
                    w_id_ex_en    = 1'b1;
                    w_ex_mem_en   = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_next_state  = ST_DRAIN;
                    if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        w_next_state = ST_HALTED;
                    end else begin
                        w_next_drain = r_drain_cnt + DRAIN_W'(1);
                    end
                end else if (w_is_halt || w_load_use) begin
                    w_id_ex_en    = 1'b1;
                    w_ex_mem_en   = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_next_state  = ST_RUN;
                    if (w_is_halt) begin
                        w_next_drain = '0;
                        w_next_state = ST_DRAIN;
                    end
                end else begin
                    {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b1111;
                    w_next_state = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                w_bubble = 1'b1;
                if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_next_wait = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_wait_cnt  <= w_next_wait;
            r_drain_cnt <= w_next_drain;
            if (!w_pc_en && (r_state == ST_RUN || r_state == ST_MEM_WAIT || r_state == ST_DRAIN) &&
                !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Mealy outputs are forced quiet while reset is held, independent of the live inputs.
    assign pc_en         = w_pc_en       & reset;
    assign if_id_en      = w_if_id_en    & reset;
    assign id_ex_en      = w_id_ex_en    & reset;
    assign ex_mem_en     = w_ex_mem_en   & reset;
    assign if_id_flush   = w_if_id_flush & reset;
    assign id_ex_flush   = w_id_ex_flush & reset;
    assign mem_wb_bubble = w_bubble      & reset;
    assign halted        = (r_state == ST_HALTED);
    assign timeout_err   = (r_state == ST_ERROR);
    assign stall_count   = r_stall_cnt;

endmodule
